// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: FSM state type, ALU op codes,
// the 5-bit op encoding and the M-extension funct3 constants.
package seq_alu_pkg;

   // Controller states; MUL and DIV are only entered when MULDIV_EN is built in
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Base ALU op codes carried in op[3:0] when op[4] is 0
   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_XOR    = 4'd2,
      ALU_OR     = 4'd3,
      ALU_AND    = 4'd4,
      ALU_SLL    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_SLT    = 4'd8,
      ALU_SLTU   = 4'd9,
      ALU_B_PASS = 4'd10
   } alu_op_t;

   // Full request op: op[4] selects an M-op, whose funct3 sits in op[2:0]
   typedef struct packed {
      logic       is_mop;
      logic [3:0] code;
   } op_t;

   localparam int OP_W = 5;

   // M-op funct3 values in RISC-V order
   localparam logic [2:0] MOP_MUL    = 3'd0;
   localparam logic [2:0] MOP_MULH   = 3'd1;
   localparam logic [2:0] MOP_MULHSU = 3'd2;
   localparam logic [2:0] MOP_MULHU  = 3'd3;
   localparam logic [2:0] MOP_DIV    = 3'd4;
   localparam logic [2:0] MOP_DIVU   = 3'd5;
   localparam logic [2:0] MOP_REM    = 3'd6;
   localparam logic [2:0] MOP_REMU   = 3'd7;

   function automatic logic mop_is_div(input logic [2:0] f);
      return f[2];
   endfunction

   function automatic logic mop_is_rem(input logic [2:0] f);
      return f[2] & f[1];
   endfunction

   function automatic logic mop_a_signed(input logic [2:0] f);
      return (f == MOP_MULH) || (f == MOP_MULHSU) || (f == MOP_DIV) || (f == MOP_REM);
   endfunction

   function automatic logic mop_b_signed(input logic [2:0] f);
      return (f == MOP_MULH) || (f == MOP_DIV) || (f == MOP_REM);
   endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu. The master drives requests, flush and
// out_ready; the slave (the ALU) returns ready, result and status flags.
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero_flag;
   logic             negative_flag;
   logic             carry_flag;
   logic             overflow_flag;

   modport master (
      output in_valid, op, src_a, src_b, flush, out_ready,
      input  in_ready, out_valid, result, zero_flag, negative_flag,
             carry_flag, overflow_flag
   );

   modport slave (
      input  in_valid, op, src_a, src_b, flush, out_ready,
      output in_ready, out_valid, result, zero_flag, negative_flag,
             carry_flag, overflow_flag
   );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply/divide engine for seq_alu: shift-add multiply and
// restoring divide, one bit per cycle for WIDTH cycles. Signed ops run on
// magnitudes and are sign-corrected on the way out. Only present when
// MULDIV_EN is defined.
`ifdef MULDIV_EN
module seq_muldiv
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [2:0]       funct,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH-1:0]   opnd;
   logic [CW-1:0]      count;
   logic               is_div;
   logic               want_alt;
   logic               negate;

   logic               neg_a;
   logic               neg_b;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;

   logic [WIDTH-1:0]   hi_n;
   logic [WIDTH-1:0]   lo_n;
   logic [WIDTH:0]     sum_ext;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign done = busy && (count == LAST);

   // Operand magnitudes and sign bookkeeping for a starting operation
   always_comb begin
      neg_a = mop_a_signed(funct) && src_a[WIDTH-1];
      neg_b = mop_b_signed(funct) && src_b[WIDTH-1];
      mag_a = neg_a ? -src_a : src_a;
      mag_b = neg_b ? -src_b : src_b;
   end

   // One iteration: add-and-shift for multiply, trial subtract for divide
   always_comb begin
      sum_ext = {1'b0, hi} + {1'b0, opnd};
      shifted = {hi, lo[WIDTH-1]};
      diff    = shifted - {1'b0, opnd};
      hi_n    = hi;
      lo_n    = lo;
      if (is_div) begin
         hi_n = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
         lo_n = {lo[WIDTH-2:0], ~diff[WIDTH]};
      end else if (lo[0]) begin
         {hi_n, lo_n} = {sum_ext, lo[WIDTH-1:1]};
      end else begin
         {hi_n, lo_n} = {1'b0, hi, lo[WIDTH-1:1]};
      end
   end

   // Final value taken from the last iteration, with sign correction applied
   always_comb begin
      prod     = {hi_n, lo_n};
      prod_fix = negate ? -prod : prod;
      quo_fix  = negate ? -lo_n : lo_n;
      rem_fix  = negate ? -hi_n : hi_n;
      if (is_div) begin
         result = want_alt ? rem_fix : quo_fix;
      end else begin
         result = want_alt ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
      end
   end

   // Load operands on start, then iterate until the last bit is consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi       <= '0;
         lo       <= '0;
         opnd     <= '0;
         count    <= '0;
         busy     <= 1'b0;
         is_div   <= 1'b0;
         want_alt <= 1'b0;
         negate   <= 1'b0;
      end else if (abort) begin
         busy  <= 1'b0;
         count <= '0;
      end else if (start) begin
         hi       <= '0;
         lo       <= mag_a;
         opnd     <= mag_b;
         count    <= '0;
         busy     <= 1'b1;
         is_div   <= mop_is_div(funct);
         want_alt <= mop_is_div(funct) ? mop_is_rem(funct) : (funct != MOP_MUL);
         negate   <= (funct == MOP_REM) ? neg_a : (neg_a ^ neg_b);
      end else if (busy) begin
         hi    <= hi_n;
         lo    <= lo_n;
         count <= count + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule
`endif

// File: rtl/seq_alu.sv
// Sequential ALU with a single-request handshake. Base ops finish in one
// cycle; the RISC-V M-ops (enabled by defining MULDIV_EN) run on the
// iterative seq_muldiv engine. Divide-by-zero and signed-overflow divides
// are resolved at accept time without iterating.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   seq_alu_if.slave bus
);

   localparam int SW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   state_t           state;
   state_t           accept_state;
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             negative_q;
   logic             carry_q;
   logic             overflow_q;

   logic [SW-1:0]    shamt;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [WIDTH-1:0] base_res;
   logic             base_c;
   logic             base_v;
   logic [WIDTH-1:0] imm_res;
   logic             imm_c;
   logic             imm_v;

   assign shamt             = bus.src_b[SW-1:0];
   assign bus.in_ready      = (state == IDLE);
   assign bus.out_valid     = out_valid_q;
   assign bus.result        = result_q;
   assign bus.zero_flag     = zero_q;
   assign bus.negative_flag = negative_q;
   assign bus.carry_flag    = carry_q;
   assign bus.overflow_flag = overflow_q;

`ifdef MULDIV_EN
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [2:0]       funct;
   logic             md_start;
   logic             md_busy;
   logic             md_done;
   logic [WIDTH-1:0] md_result;

   assign funct    = bus.op[2:0];
   assign md_start = (state == IDLE) && bus.in_valid && !bus.flush && (accept_state != DONE);

   seq_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (md_start),
      .abort  (bus.flush),
      .funct  (funct),
      .src_a  (bus.src_a),
      .src_b  (bus.src_b),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );
`endif

   // Single-cycle base ALU evaluated straight from the request operands
   always_comb begin
      sum_ext  = {1'b0, bus.src_a} + {1'b0, bus.src_b};
      diff_ext = {1'b0, bus.src_a} - {1'b0, bus.src_b};
      base_res = '0;
      base_c   = 1'b0;
      base_v   = 1'b0;
      case (bus.op[3:0])
         ALU_ADD: begin
            base_res = sum_ext[WIDTH-1:0];
            base_c   = sum_ext[WIDTH];
            base_v   = (bus.src_a[MSB] == bus.src_b[MSB]) && (sum_ext[MSB] != bus.src_a[MSB]);
         end
         ALU_SUB: begin
            base_res = diff_ext[WIDTH-1:0];
            base_c   = ~diff_ext[WIDTH];
            base_v   = (bus.src_a[MSB] != bus.src_b[MSB]) && (diff_ext[MSB] != bus.src_a[MSB]);
         end
         ALU_XOR:    base_res = bus.src_a ^ bus.src_b;
         ALU_OR:     base_res = bus.src_a | bus.src_b;
         ALU_AND:    base_res = bus.src_a & bus.src_b;
         ALU_SLL:    base_res = bus.src_a << shamt;
         ALU_SRL:    base_res = bus.src_a >> shamt;
         ALU_SRA:    base_res = $unsigned($signed(bus.src_a) >>> shamt);
         ALU_SLT:    base_res = {{(WIDTH-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
         ALU_SLTU:   base_res = {{(WIDTH-1){1'b0}}, bus.src_a < bus.src_b};
         ALU_B_PASS: base_res = bus.src_b;
         default:    base_res = '0;
      endcase
   end

   // Decide where an accepted request goes and what a one-cycle result is
   always_comb begin
      imm_res      = base_res;
      imm_c        = base_c;
      imm_v        = base_v;
      accept_state = DONE;
      if (bus.op[4]) begin
         imm_res = '0;
         imm_c   = 1'b0;
         imm_v   = 1'b0;
`ifdef MULDIV_EN
         if (!mop_is_div(funct)) begin
            accept_state = MUL;
         end else if (bus.src_b == '0) begin
            imm_res = mop_is_rem(funct) ? bus.src_a : '1;
         end else if (mop_a_signed(funct) && (bus.src_a == MOST_NEG) && (bus.src_b == '1)) begin
            imm_res = mop_is_rem(funct) ? '0 : bus.src_a;
         end else begin
            accept_state = DIV;
         end
`endif
      end
   end

   // Controller FSM with registered result, flags and out_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         negative_q  <= 1'b0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (bus.flush) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         negative_q  <= 1'b0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  state <= accept_state;
                  if (accept_state == DONE) begin
                     out_valid_q <= 1'b1;
                     result_q    <= imm_res;
                     zero_q      <= (imm_res == '0);
                     negative_q  <= imm_res[MSB];
                     carry_q     <= imm_c;
                     overflow_q  <= imm_v;
                  end
               end
            end
`ifdef MULDIV_EN
            MUL, DIV: begin
               if (md_done) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= md_result;
                  zero_q      <= (md_result == '0);
                  negative_q  <= md_result[MSB];
                  carry_q     <= 1'b0;
                  overflow_q  <= 1'b0;
               end else if (!md_busy) begin
                  state <= IDLE;
               end
            end
`endif
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus randomized
// base ops and M-ops against an arithmetic reference model. Expectations for
// op[4]=1 requests follow whether MULDIV_EN is defined.
module tb_seq_alu;
   import seq_alu_pkg::*;

   localparam int W = 32;
   localparam longint MAX_S = 64'sd2147483647;
   localparam longint MIN_S = -64'sd2147483648;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        n;
      logic        c;
      logic        v;
      logic [7:0]  lat;
   } exp_t;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;

   seq_alu_if #(.WIDTH(W)) bus ();
   seq_alu_if #(.WIDTH(8)) bus8 ();

   seq_alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   seq_alu #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference behaviour computed with plain integer arithmetic
   function automatic exp_t ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t            e;
      longint          sa;
      longint          sb;
      longint          sv;
      longint          p;
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = 64'(a);
      ub = 64'(b);
      e = '0;
      e.lat = 8'd1;
      if (!op[4]) begin
         case (op[3:0])
            4'd0: begin
               pu = ua + ub;
               e.res = pu[31:0];
               e.c = (pu > 64'hFFFF_FFFF);
               sv = sa + sb;
               e.v = (sv > MAX_S) || (sv < MIN_S);
            end
            4'd1: begin
               pu = ua - ub;
               e.res = pu[31:0];
               e.c = (ua >= ub);
               sv = sa - sb;
               e.v = (sv > MAX_S) || (sv < MIN_S);
            end
            4'd2:  e.res = a ^ b;
            4'd3:  e.res = a | b;
            4'd4:  e.res = a & b;
            4'd5:  e.res = a << b[4:0];
            4'd6:  e.res = a >> b[4:0];
            4'd7:  e.res = $unsigned($signed(a) >>> b[4:0]);
            4'd8:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  e.res = (ua < ub) ? 32'd1 : 32'd0;
            4'd10: e.res = b;
            default: e.res = 32'd0;
         endcase
      end else begin
`ifdef MULDIV_EN
         case (op[2:0])
            3'd0: begin p = sa * sb; e.res = p[31:0]; e.lat = 8'(W + 1); end
            3'd1: begin p = sa * sb; e.res = p[63:32]; e.lat = 8'(W + 1); end
            3'd2: begin p = sa * longint'(ub); e.res = p[63:32]; e.lat = 8'(W + 1); end
            3'd3: begin pu = ua * ub; e.res = pu[63:32]; e.lat = 8'(W + 1); end
            default: begin
               if (b == 32'd0) begin
                  e.res = op[1] ? a : 32'hFFFF_FFFF;
               end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  e.res = op[1] ? 32'd0 : a;
               end else begin
                  e.lat = 8'(W + 1);
                  case (op[2:0])
                     3'd4:    begin sv = sa / sb; e.res = sv[31:0]; end
                     3'd5:    begin pu = ua / ub; e.res = pu[31:0]; end
                     3'd6:    begin sv = sa % sb; e.res = sv[31:0]; end
                     default: begin pu = ua % ub; e.res = pu[31:0]; end
                  endcase
               end
            end
         endcase
`else
         e.res = 32'd0;
`endif
      end
      e.z = (e.res == 32'd0);
      e.n = e.res[31];
      return e;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] expected);
      compared++;
      if (got !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, expected);
      end
   endtask

   // Present one request, wait for acceptance, then count cycles to out_valid
   task automatic apply_stimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check_output("in_ready_before_req", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.op = op;
      bus.src_a = a;
      bus.src_b = b;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.op = 5'($urandom);
      bus.src_a = $urandom;
      bus.src_b = $urandom;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_output("release_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   lat;
      e = ref_model(op, a, b);
      apply_stimulus(op, a, b, lat);
      check_output($sformatf("%s_lat", tag), 64'(lat), 64'(e.lat));
      check_output($sformatf("%s_res", tag), 64'(bus.result), 64'(e.res));
      check_output($sformatf("%s_flags", tag),
                   64'({bus.zero_flag, bus.negative_flag, bus.carry_flag, bus.overflow_flag}),
                   64'({e.z, e.n, e.c, e.v}));
      release_result();
   endtask

   initial begin
      exp_t e;
      int   lat;
      logic seen;
      logic [4:0] rop;

      compared = 0;
      mismatched = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.op = '0;
      bus.src_a = '0;
      bus.src_b = '0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      bus8.in_valid = 1'b0;
      bus8.op = '0;
      bus8.src_a = '0;
      bus8.src_b = '0;
      bus8.flush = 1'b0;
      bus8.out_ready = 1'b0;

      repeat (3) @(negedge clk);
      check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_output("rst_result", 64'(bus.result), 64'd0);
      check_output("rst_flags", 64'({bus.zero_flag, bus.negative_flag, bus.carry_flag, bus.overflow_flag}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("rst_in_ready", 64'(bus.in_ready), 64'd1);

      $display("[TB] directed corner cases");
      do_op("add_ovf", 5'h00, 32'h7FFF_FFFF, 32'h0000_0001);
      do_op("add_carry", 5'h00, 32'hFFFF_FFFF, 32'h0000_0001);
      do_op("sub_borrow", 5'h01, 32'd0, 32'd1);
      do_op("sub_ok", 5'h01, 32'd5, 32'd3);
      do_op("sra", 5'h07, 32'h8000_0000, 32'd4);
      do_op("slt", 5'h08, 32'hFFFF_FFFE, 32'd3);
      do_op("undef", 5'h0F, 32'h1234_5678, 32'h1);
      do_op("mulh", 5'h11, 32'hFFFF_FFFE, 32'd3);
      do_op("mulhu", 5'h13, 32'hFFFF_FFFF, 32'd2);
      do_op("div_ovf", 5'h14, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op("divu_zero", 5'h15, 32'd5, 32'd0);
      do_op("rem_neg", 5'h16, 32'hFFFF_FFF9, 32'd2);
      do_op("rem_zero", 5'h16, 32'hFFFF_FFF9, 32'd0);

      $display("[TB] hold result while out_ready is low");
      e = ref_model(5'h02, 32'hA5A5_0F0F, 32'h0F0F_F0F0);
      apply_stimulus(5'h02, 32'hA5A5_0F0F, 32'h0F0F_F0F0, lat);
      check_output("hold_lat", 64'(lat), 64'(e.lat));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_output("hold_result", 64'(bus.result), 64'(e.res));
         check_output("hold_valid", 64'(bus.out_valid), 64'd1);
         check_output("hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      release_result();
      check_output("after_release_valid", 64'(bus.out_valid), 64'd0);

      $display("[TB] flush behaviour");
      apply_stimulus(5'h00, 32'd7, 32'd8, lat);
      bus.flush = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      check_output("flush_done_valid", 64'(bus.out_valid), 64'd0);
      check_output("flush_done_ready", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.flush = 1'b1;
      bus.op = 5'h00;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
      check_output("flush_beats_valid", 64'(bus.out_valid), 64'd0);
      check_output("flush_beats_ready", 64'(bus.in_ready), 64'd1);
`ifdef MULDIV_EN
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op = 5'h15;
      bus.src_a = 32'd100;
      bus.src_b = 32'd7;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check_output("flush_div_ready", 64'(bus.in_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) seen = 1'b1;
         @(negedge clk);
      end
      check_output("flush_div_no_valid", 64'(seen), 64'd0);
`endif
      do_op("add_after_flush", 5'h00, 32'd2, 32'd3);

      $display("[TB] randomized base ops");
      for (int i = 0; i < 40; i++) begin
         rop = {1'b0, 4'($urandom_range(0, 15))};
         do_op($sformatf("rnd_base%0d", i), rop, pick_operand(), pick_operand());
      end

      $display("[TB] randomized M-ops");
      for (int i = 0; i < 30; i++) begin
         rop = {1'b1, 1'($urandom), 3'($urandom_range(0, 7))};
         do_op($sformatf("rnd_mop%0d", i), rop, pick_operand(), pick_operand());
      end

      $display("[TB] reset during an operation");
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op = 5'h11;
      bus.src_a = 32'hFFFF_FFFE;
      bus.src_b = 32'd3;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("midrst_valid", 64'(bus.out_valid), 64'd0);
      check_output("midrst_result", 64'(bus.result), 64'd0);
      check_output("midrst_flags", 64'({bus.zero_flag, bus.negative_flag, bus.carry_flag, bus.overflow_flag}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) seen = 1'b1;
         @(negedge clk);
      end
      check_output("midrst_no_valid", 64'(seen), 64'd0);

      $display("[TB] 8-bit instance shift");
      @(negedge clk);
      bus8.in_valid = 1'b1;
      bus8.op = 5'h05;
      bus8.src_a = 8'h81;
      bus8.src_b = 8'h01;
      @(posedge clk);
      @(negedge clk);
      bus8.in_valid = 1'b0;
      check_output("w8_valid", 64'(bus8.out_valid), 64'd1);
      check_output("w8_sll", 64'(bus8.result), 64'h02);
      bus8.out_ready = 1'b1;
      @(negedge clk);
      bus8.out_ready = 1'b0;
      check_output("w8_release", 64'(bus8.in_ready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal values are powers of two from 8 to 64.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  5  operation code: op[4]=0 selects the existing 4-bit ALU op codes in op[3:0]; op[4]=1 selects an M-op in op[2:0] (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, in RISC-V funct3 order).
REQ-007 src_a, src_b  input  WIDTH  operands.
REQ-008 flush  input  1  synchronous abort of any in-flight operation.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero_flag, negative_flag, carry_flag, overflow_flag  output  1 each  status flags for result.

Function
REQ-013 The FSM SHALL have the states IDLE, MUL, DIV and DONE; in_ready=1 only in IDLE.
REQ-014 A request SHALL be accepted when in_valid and in_ready are both high; operands and op are captured that cycle.
REQ-015 A base op SHALL go IDLE->DONE, so out_valid rises in the cycle after acceptance (latency 1).
REQ-016 Base-op semantics SHALL be: ADD/SUB with carry (SUB carry = not-borrow) and signed overflow; XOR, OR, AND; SLL/SRL/SRA by src_b[$clog2(WIDTH)-1:0]; SLT/SLTU giving 1 or 0; B_PASS; undefined codes give 0.
REQ-017 MUL* ops SHALL use a shift-add datapath, one bit per cycle, for WIDTH cycles in MUL; latency is WIDTH+1.
REQ-018 MUL SHALL return the low WIDTH bits; MULH, MULHSU and MULHU SHALL return the high WIDTH bits of the 2*WIDTH product, signed x signed, signed x unsigned and unsigned x unsigned respectively.
REQ-019 DIV* ops SHALL use a restoring datapath, one bit per cycle, for WIDTH cycles in DIV; signed ops operate on magnitudes and sign-correct the result (remainder takes the dividend's sign).
REQ-020 Divide by zero SHALL skip DIV and go straight to DONE (latency 1), with quotient all-ones and remainder = src_a.
REQ-021 Signed overflow (most-negative / -1) SHALL skip DIV (latency 1), with quotient = src_a and remainder 0.
REQ-022 DONE SHALL hold result, flags and out_valid stable until out_ready=1, then go to IDLE next cycle; out_ready is ignored outside DONE.
REQ-023 zero_flag SHALL be (result==0) and negative_flag SHALL be result[WIDTH-1] for all ops; carry_flag and overflow_flag SHALL be 0 except for ADD and SUB.
REQ-024 flush SHALL force IDLE next cycle from any state, drop any result without out_valid, and win over a simultaneous in_valid or out_ready.
REQ-025 At most one operation SHALL be in flight; maximum throughput is one op per two cycles.

Reset
REQ-026 While rst_n=0, state SHALL be IDLE and out_valid, result and all flags 0; in_ready=1 after release.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no output.

Configuration
REQ-028 With MULDIV_EN defined, the M-ops SHALL be implemented as above.
REQ-029 Without MULDIV_EN, no MUL/DIV datapath SHALL exist and any op[4]=1 request SHALL complete as a base op with latency 1, result 0 and zero_flag=1.

Structure
REQ-030 FSM state typedef, the 5-bit op encoding and the M-op funct3 constants SHALL live in the shared package alongside the existing ALU op codes.
REQ-031 The iterative multiply/divide datapath SHALL be the sub-module seq_muldiv (start/busy/done), instantiated only under MULDIV_EN.

Verification
REQ-032 ADD 0x7FFFFFFF+1, WIDTH=32 -> result 0x80000000, overflow=1, carry=0, negative=1, out_valid 1 cycle after accept.
REQ-033 MULH -2 x 3 -> result 0xFFFFFFFF, out_valid 33 cycles after accept; MULHU 0xFFFFFFFF x 2 -> 0x00000001.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, latency 1; DIVU 5/0 -> 0xFFFFFFFF; REM -7/2 -> 0xFFFFFFFF.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0 throughout; pulse out_ready -> IDLE next cycle.
REQ-036 flush at cycle 10 of a DIV -> IDLE next cycle, no out_valid; a following ADD 2+3 -> 5.
REQ-037 rst_n low mid-MUL -> outputs 0 immediately; WIDTH=8 build: SLL 0x81 by 1 -> 0x02.
